// File: rtl/wb_merge_if.sv
// Channel-side bus of the writeback merge stage.
// The producers drive the master modport and wb_merge takes the slave modport.
interface wb_merge_if #(
  parameter int NCH = 2,
  parameter int DW  = 32,
  parameter int RW  = 5
);
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH-1:0]    ch_wen;
  logic [NCH-1:0]    ch_halt;
  logic [NCH*RW-1:0] ch_wsel;
  logic [NCH*DW-1:0] ch_wdat;

  modport master (
    output ch_valid, ch_wen, ch_halt, ch_wsel, ch_wdat,
    input  ch_ready
  );

  modport slave (
    input  ch_valid, ch_wen, ch_halt, ch_wsel, ch_wdat,
    output ch_ready
  );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: writeback stage that merges NCH result channels into the single
// register-file write port. Each channel owns a DEPTH-entry FIFO and an
// arbiter pops one entry per cycle into a registered WEN/wsel/wdat output.
// A popped halt marker sets a sticky halt that freezes the stage until reset.
// Build option WB_FIXED_PRIO_EN: when defined, the arbiter uses fixed priority
// (lowest channel index wins) and no round-robin pointer is built; by default
// the arbiter is round-robin.
module wb_merge #(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int RW    = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  wb_merge_if.slave     ch,
  output logic          WEN,
  output logic [RW-1:0] wsel,
  output logic [DW-1:0] wdat,
  output logic          halt,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [RW-1:0] mem_wsel [NCH][DEPTH];
  logic [DW-1:0] mem_wdat [NCH][DEPTH];
  logic          mem_halt [NCH][DEPTH];

  logic [PW-1:0] rd_ptr [NCH];
  logic [PW-1:0] wr_ptr [NCH];
  logic [CW-1:0] cnt    [NCH];

  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] store;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  logic          gnt_vld;
  logic [GW-1:0] gnt;
  logic          pop_en;
  logic [RW-1:0] sel_wsel;
  logic [DW-1:0] sel_wdat;
  logic          sel_halt;

`ifndef WB_FIXED_PRIO_EN
  logic [GW-1:0] rr_ptr;
`endif

  // FIFO status flags and which incoming entries are worth storing
  always_comb begin
    empty = '0;
    full  = '0;
    store = '0;
    for (int i = 0; i < NCH; i++) begin
      empty[i] = (cnt[i] == '0);
      full[i]  = (cnt[i] == CW'(DEPTH));
      // entries that neither write a real register nor halt are swallowed
      store[i] = ch.ch_halt[i] | (ch.ch_wen[i] & (ch.ch_wsel[i*RW +: RW] != '0));
    end
  end

  // ready depends only on current state, so a same-cycle pop never frees a slot
  assign ready       = {NCH{nRST & ~halt & ~flush}} & ~full;
  assign ch.ch_ready = ready;
  assign push        = ch.ch_valid & ready & store;

  // arbiter: pick one non-empty FIFO to pop this cycle
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
`ifdef WB_FIXED_PRIO_EN
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        gnt_vld = 1'b1;
        gnt     = GW'(i);
      end
    end
`else
    for (int k = 0; k < NCH; k++) begin
      logic [GW:0] idx;
      idx = {1'b0, rr_ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(NCH)) idx = idx - (GW+1)'(NCH);
      if (!gnt_vld && !empty[idx[GW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[GW-1:0];
      end
    end
`endif
  end

  assign pop_en   = gnt_vld & ~halt & ~flush;
  assign sel_wsel = mem_wsel[gnt][rd_ptr[gnt]];
  assign sel_wdat = mem_wdat[gnt][rd_ptr[gnt]];
  assign sel_halt = mem_halt[gnt][rd_ptr[gnt]];

  // one-hot pop vector from the grant
  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) pop[i] = pop_en && (gnt == GW'(i));
  end

  // FIFO storage is written without reset; occupancy lives in cnt
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem_wsel[i][wr_ptr[i]] <= ch.ch_wsel[i*RW +: RW];
        mem_wdat[i][wr_ptr[i]] <= ch.ch_wdat[i*DW +: DW];
        mem_halt[i][wr_ptr[i]] <= ch.ch_halt[i];
      end
    end
  end

  // FIFO pointers and occupancy; reset and flush both empty every FIFO
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      for (int i = 0; i < NCH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= (wr_ptr[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= (rd_ptr[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

`ifndef WB_FIXED_PRIO_EN
  // round-robin pointer moves just past the last winner and holds when idle
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (pop_en) begin
      rr_ptr <= (gnt == GW'(NCH - 1)) ? '0 : gnt + 1'b1;
    end
  end
`endif

  // registered write port and sticky halt
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      WEN  <= 1'b0;
      wsel <= '0;
      wdat <= '0;
      halt <= 1'b0;
    end else if (flush) begin
      WEN <= 1'b0;
    end else if (pop_en) begin
      if (sel_halt) begin
        WEN  <= 1'b0;
        halt <= 1'b1;
      end else begin
        WEN  <= 1'b1;
        wsel <= sel_wsel;
        wdat <= sel_wdat;
      end
    end else begin
      WEN <= 1'b0;
    end
  end

  assign busy = (|(~empty)) | WEN;

endmodule
